ex_muldiv_unit: RTL

//  EX-stage responder to the operations the ID/EX register issues: iterative 32-bit MULT/MULTU/DIV/DIVU.

---
 rtl/ex_muldiv_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage: shift-add multiply, restoring divide, HI/LO result.
// Optional MULDIV_EARLY_OUT_EN: multiply leaves CALC once the remaining multiplier bits are all zero.
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [WIDTH-1:0] rt_data_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_by_zero_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state;
  logic               is_div, neg_res, neg_rem, dbz;
  logic [CW-1:0]      counter;
  logic [2*WIDTH-1:0] acc;   // MUL: running product; DIV: {remainder, quotient/dividend}
  logic [2*WIDTH-1:0] opb;   // MUL: shifted multiplicand; DIV: divisor in low half
  logic [WIDTH-1:0]   mpl;

  logic               accept, op_div, op_signed, rs_neg, rt_neg, rt_zero;
  logic               skip_calc, calc_last;
  logic [WIDTH-1:0]   rs_mag, rt_mag, quo_fix, rem_fix;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] prod_fix;

  assign op_div    = op_i[1];
  assign op_signed = op_i[0];
  assign rs_neg    = op_signed && rs_data_i[WIDTH-1];
  assign rt_neg    = op_signed && rt_data_i[WIDTH-1];
  assign rs_mag    = rs_neg ? -rs_data_i : rs_data_i;
  assign rt_mag    = rt_neg ? -rt_data_i : rt_data_i;
  assign rt_zero   = (rt_data_i == '0);

  assign accept  = (state == IDLE || state == DONE) && start_i && !flush_i;
  assign stall_o = accept || state == CALC || state == FIX;
  assign busy_o  = (state != IDLE);

  // Restoring step: shift the next dividend bit into the remainder and try the subtract.
  assign trial    = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb[WIDTH-1:0]};
  assign prod_fix = neg_res ? -acc : acc;
  assign quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

`ifdef MULDIV_EARLY_OUT_EN
  assign skip_calc = op_div ? rt_zero : (rt_mag == '0);
  assign calc_last = is_div ? (counter == CW'(1)) : (mpl[WIDTH-1:1] == '0);
`else
  assign skip_calc = op_div && rt_zero;
  assign calc_last = (counter == CW'(1));
`endif

  // NOTE: every register here, datapath included, uses non-blocking assignment and
  // takes the async reset, so the outputs and the FSM are defined without a clock edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= IDLE;
      is_div        <= 1'b0;
      neg_res       <= 1'b0;
      neg_rem       <= 1'b0;
      dbz           <= 1'b0;
      counter       <= '0;
      acc           <= '0;
      opb           <= '0;
      mpl           <= '0;
      hi_o          <= '0;
      lo_o          <= '0;
      done_o        <= 1'b0;
      div_by_zero_o <= 1'b0;
    end else if (flush_i) begin
      state         <= IDLE;
      done_o        <= 1'b0;
      div_by_zero_o <= 1'b0;
    end else begin
      done_o        <= 1'b0;
      div_by_zero_o <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (start_i) begin
            is_div  <= op_div;
            counter <= CW'(WIDTH);
            neg_res <= rs_neg ^ rt_neg;
            neg_rem <= op_div && rs_neg;
            dbz     <= op_div && rt_zero;
            mpl     <= rt_mag;
            if (op_div && rt_zero) begin
              acc <= {rs_data_i, {WIDTH{1'b1}}};
            end else if (op_div) begin
              acc <= {{WIDTH{1'b0}}, rs_mag};
              opb <= {{WIDTH{1'b0}}, rt_mag};
            end else begin
              acc <= '0;
              opb <= {{WIDTH{1'b0}}, rs_mag};
            end
            state <= skip_calc ? FIX : CALC;
          end
        end
        CALC: begin
          counter <= counter - 1'b1;
          if (is_div) begin
            if (!trial[WIDTH]) acc <= {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else               acc <= {acc[2*WIDTH-2:0], 1'b0};
          end else begin
            if (mpl[0]) acc <= acc + opb;
            opb <= opb << 1;
            mpl <= mpl >> 1;
          end
          if (calc_last) state <= FIX;
        end
        FIX: begin
          if (dbz) begin
            {hi_o, lo_o} <= acc;
          end else if (is_div) begin
            hi_o <= rem_fix;
            lo_o <= quo_fix;
          end else begin
            {hi_o, lo_o} <= prod_fix;
          end
          done_o        <= 1'b1;
          div_by_zero_o <= dbz;
          state         <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
